// File: rtl/spawn_arbiter_if.sv
// Bus bundle for spawn_arbiter: Avalon-MM register port plus the
// per-requester spawn handshake and the starvation interrupt.
interface spawn_arbiter_if #(
   parameter int NUM_REQ = 2
);
   logic [1:0]         address;
   logic               chipselect;
   logic               write_n;
   logic [31:0]        writedata;
   logic [31:0]        readdata;
   logic [NUM_REQ-1:0] spawn_req;
   logic [NUM_REQ-1:0] spawn_ack;
   logic [NUM_REQ-1:0] spawn_gnt;
   logic               spawn_valid;
   logic [19:0]        spawn_pos;
   logic               irq;

   modport slave (
      input  address, chipselect, write_n, writedata, spawn_req, spawn_ack,
      output readdata, spawn_gnt, spawn_valid, spawn_pos, irq
   );

   modport master (
      output address, chipselect, write_n, writedata, spawn_req, spawn_ack,
      input  readdata, spawn_gnt, spawn_valid, spawn_pos, irq
   );
endinterface

// File: rtl/spawn_arbiter.sv
// spawn_arbiter: queues software-written 20-bit spawn positions and hands
// them out one at a time to NUM_REQ requesters using round-robin arbitration,
// a valid/ack handshake and a post-ack cooldown.
// Optional starvation interrupt is built when SPAWN_ARB_IRQ_EN is defined;
// otherwise irq is tied low.
module spawn_arbiter #(
   parameter int          NUM_REQ    = 2,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] COOLDOWN   = 16'd1000
) (
   input  logic            clk,
   input  logic            reset_n,
   spawn_arbiter_if.slave  bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_COOL} state_t;

   state_t             state_reg, state_next;
   logic [3:0]         count_reg, count_next;
   logic [AW-1:0]      wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0]      rd_ptr_reg, rd_ptr_next;
   logic               enable_reg, enable_next;
   logic               overflow_reg, overflow_next;
   logic [2:0]         last_id_reg, last_id_next;
   logic [19:0]        last_pos_reg, last_pos_next;
   logic [15:0]        cnt_reg, cnt_next;
   logic               valid_reg, valid_next;
   logic [NUM_REQ-1:0] gnt_reg, gnt_next;
   logic [19:0]        pos_reg, pos_next;

   logic [19:0]        mem [FIFO_DEPTH];

   logic               wr_en, push, ctrl_wr, push_ok, pop;
   logic               full, empty;
   logic [2:0]         start_id;
   logic [NUM_REQ-1:0] hi_mask, masked_req, pick, win_onehot;
   logic [NUM_REQ-1:0] sel_b0, sel_b1, sel_b2;
   logic [2:0]         win_id;
   logic               unused_bits;

   assign wr_en   = bus.chipselect & ~bus.write_n;
   assign push    = wr_en & (bus.address == 2'd0);
   assign ctrl_wr = wr_en & (bus.address == 2'd1);
   assign full    = (count_reg == 4'(FIFO_DEPTH));
   assign empty   = (count_reg == 4'd0);
   assign push_ok = push & ~full;
   assign unused_bits = ^bus.writedata[31:20];

   // Round-robin: prefer requesters at or above the slot after the last
   // winner; if none, wrap around to the lowest asserted requester.
   assign start_id   = (last_id_reg == 3'(NUM_REQ - 1)) ? 3'd0 : last_id_reg + 3'd1;
   assign masked_req = bus.spawn_req & hi_mask;
   assign pick       = (|masked_req) ? masked_req : bus.spawn_req;
   assign win_onehot = pick & (~pick + ONE);
   assign win_id     = {|sel_b2, |sel_b1, |sel_b0};

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign hi_mask[gi] = (3'(gi) >= start_id);
         assign sel_b0[gi]  = win_onehot[gi] & ((gi & 1) != 0);
         assign sel_b1[gi]  = win_onehot[gi] & ((gi & 2) != 0);
         assign sel_b2[gi]  = win_onehot[gi] & ((gi & 4) != 0);
      end
   endgenerate

   // Position queue storage; no reset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= bus.writedata[19:0];
      end
   end

   // Grant FSM next-state and handshake outputs.
   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      valid_next    = valid_reg;
      gnt_next      = gnt_reg;
      pos_next      = pos_reg;
      last_id_next  = last_id_reg;
      last_pos_next = last_pos_reg;
      pop           = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (enable_reg && !empty && (|bus.spawn_req)) begin
               pop           = 1'b1;
               pos_next      = mem[rd_ptr_reg];
               last_pos_next = mem[rd_ptr_reg];
               gnt_next      = win_onehot;
               last_id_next  = win_id;
               valid_next    = 1'b1;
               state_next    = S_GRANT;
            end
         end
         S_GRANT: begin
            // gnt_reg is one-hot on last_id, so this only sees the winner's ack.
            if (|(bus.spawn_ack & gnt_reg)) begin
               valid_next = 1'b0;
               gnt_next   = '0;
               if (COOLDOWN == 16'd0) begin
                  state_next = S_IDLE;
               end else begin
                  cnt_next   = COOLDOWN;
                  state_next = S_COOL;
               end
            end
         end
         S_COOL: begin
            if (cnt_reg <= 16'd1) begin
               cnt_next   = 16'd0;
               state_next = S_IDLE;
            end else begin
               cnt_next = cnt_reg - 16'd1;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Queue pointers, occupancy and control register updates.
   always_comb begin
      wr_ptr_next   = wr_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;
      count_next    = count_reg;
      enable_next   = enable_reg;
      overflow_next = overflow_reg;
      if (push_ok) begin
         wr_ptr_next = wr_ptr_reg + 1'b1;
      end
      if (pop) begin
         rd_ptr_next = rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop})
         2'b10:   count_next = count_reg + 4'd1;
         2'b01:   count_next = count_reg - 4'd1;
         default: count_next = count_reg;
      endcase
      if (ctrl_wr) begin
         enable_next = bus.writedata[0];
         if (bus.writedata[1]) begin
            overflow_next = 1'b0;
         end
      end
      if (push && full) begin
         overflow_next = 1'b1;
      end
   end

   // State register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= S_IDLE;
         count_reg    <= 4'd0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         enable_reg   <= 1'b0;
         overflow_reg <= 1'b0;
         last_id_reg  <= 3'(NUM_REQ - 1);
         last_pos_reg <= 20'd0;
         cnt_reg      <= 16'd0;
         valid_reg    <= 1'b0;
         gnt_reg      <= '0;
         pos_reg      <= 20'd0;
      end else begin
         state_reg    <= state_next;
         count_reg    <= count_next;
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         enable_reg   <= enable_next;
         overflow_reg <= overflow_next;
         last_id_reg  <= last_id_next;
         last_pos_reg <= last_pos_next;
         cnt_reg      <= cnt_next;
         valid_reg    <= valid_next;
         gnt_reg      <= gnt_next;
         pos_reg      <= pos_next;
      end
   end

`ifdef SPAWN_ARB_IRQ_EN
   logic irq_reg, irq_next;

   // Starvation flag: a requester waits while the queue is empty; any push
   // or an overflow-clear write acknowledges it (clear has priority).
   always_comb begin
      irq_next = irq_reg;
      if (push || (ctrl_wr && bus.writedata[1])) begin
         irq_next = 1'b0;
      end else if ((state_reg == S_IDLE) && enable_reg && empty && (|bus.spawn_req)) begin
         irq_next = 1'b1;
      end
   end

   // Interrupt register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_reg <= 1'b0;
      end else begin
         irq_reg <= irq_next;
      end
   end

   assign bus.irq = irq_reg;
`else
   assign bus.irq = 1'b0;
`endif

   assign bus.spawn_valid = valid_reg;
   assign bus.spawn_gnt   = gnt_reg;
   assign bus.spawn_pos   = pos_reg;

   // Zero-wait register read mux.
   always_comb begin
      bus.readdata = 32'd0;
      case (bus.address)
         2'd0: bus.readdata = {16'd0, 8'(bus.spawn_req), (state_reg != S_IDLE),
                               overflow_reg, empty, full, count_reg};
         2'd1: bus.readdata = {31'd0, enable_reg};
         2'd2: bus.readdata = {9'd0, last_id_reg, last_pos_reg};
         2'd3: bus.readdata = {16'd0, cnt_reg};
         default: bus.readdata = 32'd0;
      endcase
   end
endmodule
